// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program sequencer in front of the instruction decoder.
// Fetches 16-bit words from a synchronous instruction memory, pulses them into
// the decoder, and hands ordinary instructions to the execute stage over a
// req/ack handshake. Jump and halt opcodes are resolved here and never reach
// the execute stage.
module fetch_sequencer #(
  parameter int         ADDR_W  = 8,
  parameter logic [3:0] JMP_OP  = 4'hE,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic              id_en,
  output logic [15:0]       id_instr,
  output logic              exec_req,
  input  logic              exec_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       retired,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_MEM, S_DECODE, S_EXEC, S_HALT
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_jmp_tgt;
  logic [15:0]       r_ir;
  logic [15:0]       r_retired;
  logic              w_start_ok;
  logic              w_is_halt;
  logic              w_is_jmp;

  // start is honoured only when the sequencer is parked
  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_HALT);
  assign w_is_halt  = (r_ir[15:12] == HALT_OP);
  assign w_is_jmp   = (r_ir[15:12] == JMP_OP);

  // Jump target is the 12-bit immediate, truncated or zero-extended to the PC
  generate
    if (ADDR_W > 12) begin : g_tgt_wide
      assign w_jmp_tgt = {{(ADDR_W-12){1'b0}}, r_ir[11:0]};
    end else begin : g_tgt_narrow
      assign w_jmp_tgt = r_ir[ADDR_W-1:0];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start_ok) w_next = S_FETCH;
      S_FETCH:    w_next = S_WAIT_MEM;
      S_WAIT_MEM: w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_halt)     w_next = S_HALT;
        else if (w_is_jmp) w_next = S_FETCH;
        else               w_next = S_EXEC;
      end
      S_EXEC:     if (exec_ack) w_next = S_FETCH;
      S_HALT:     if (w_start_ok) w_next = S_FETCH;
      default:    w_next = S_IDLE;
    endcase
  end

  // Output decode; all strobes are pure functions of state so reset clears them at once
  always_comb begin
    imem_rd  = 1'b0;
    id_en    = 1'b0;
    exec_req = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_FETCH:    begin imem_rd  = 1'b1; busy = 1'b1; end
      S_WAIT_MEM: begin busy     = 1'b1; end
      S_DECODE:   begin id_en    = 1'b1; busy = 1'b1; end
      S_EXEC:     begin exec_req = 1'b1; busy = 1'b1; end
      S_HALT:     begin halted   = 1'b1; end
      default:    ;
    endcase
  end

  // PC, instruction register and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_pc      <= start_addr;
            r_retired <= '0;
          end
        end
        S_WAIT_MEM: r_ir <= imem_data;
        S_DECODE:   if (!w_is_halt && w_is_jmp) r_pc <= w_jmp_tgt;
        S_EXEC: begin
          if (exec_ack) begin
            r_pc      <= r_pc + ADDR_W'(1);
            r_retired <= r_retired + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign id_instr  = r_ir;
  assign retired   = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: synchronous memory model, scoreboard queues of
// expected decode events (word + cycle after start) and fetch addresses.
module tb_fetch_sequencer;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, start, exec_ack;
  logic [AW-1:0] start_addr, imem_addr, pc;
  logic          imem_rd, id_en, exec_req, busy, halted;
  logic [15:0]   imem_data, id_instr, retired;
  logic [15:0]   mem [256];

  int chk_cnt = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [15:0] instr;
    int          cyc;
  } dec_t;

  dec_t          exp_dec[$], obs_dec[$];
  logic [AW-1:0] exp_fetch[$], obs_fetch[$];
  int            req_cycles, pc_drift, halt_cyc;

  fetch_sequencer #(.ADDR_W(AW), .JMP_OP(4'hE), .HALT_OP(4'hF)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_en(id_en), .id_instr(id_instr), .exec_req(exec_req), .exec_ack(exec_ack),
    .pc(pc), .retired(retired), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid the cycle after the read strobe
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  // Start a program and record decode/fetch/exec activity until halted (bounded).
  // ack_wait = EXEC cycles with ack low before acking; spur = inject junk ack/start.
  task automatic run_prog(input logic [AW-1:0] sa, input int ack_wait, input bit spur);
    int seen;
    logic [AW-1:0] req_pc;
    dec_t d;
    obs_dec.delete(); obs_fetch.delete();
    req_cycles = 0; pc_drift = 0; halt_cyc = -1; seen = 0; req_pc = '0;
    start = 1'b1; start_addr = sa; exec_ack = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) begin
        start = spur && (c == 1 || c == 2 || c == 4);
        if (spur) start_addr = 8'h77;
      end
      exec_ack = exec_req ? (seen >= ack_wait) : (spur && (c == 1 || c == 3));
      @(negedge clk);
      if (imem_rd) obs_fetch.push_back(imem_addr);
      if (id_en) begin d.instr = id_instr; d.cyc = c; obs_dec.push_back(d); end
      if (exec_req) begin
        if (seen == 0) req_pc = pc;
        else if (pc != req_pc) pc_drift++;
        req_cycles++; seen++;
      end else seen = 0;
      if (halted && c > 0) begin halt_cyc = c; break; end
      @(posedge clk); #1;
    end
    start = 1'b0; exec_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; exec_ack = 1'b0; start_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({imem_rd, imem_addr, id_en, id_instr, exec_req, pc, retired, busy, halted} !== '0)
      $display("FAIL reset_hold: outputs nonzero during reset (pc=%h retired=%h busy=%b)", pc, retired, busy);
    else pass_cnt++;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({imem_rd, imem_addr, id_en, id_instr, exec_req, pc, retired, busy, halted} !== '0)
      $display("FAIL reset_release: outputs nonzero after release (busy=%b halted=%b)", busy, halted);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_straight_line();
    dec_t e, o;
    mem[8'h10] = 16'h1041; mem[8'h11] = 16'h2082; mem[8'h12] = 16'hF000;
    e.instr = 16'h1041; e.cyc = 3;  exp_dec.push_back(e);
    e.instr = 16'h2082; e.cyc = 7;  exp_dec.push_back(e);
    e.instr = 16'hF000; e.cyc = 11; exp_dec.push_back(e);
    exp_fetch.push_back(8'h10); exp_fetch.push_back(8'h11); exp_fetch.push_back(8'h12);
    run_prog(8'h10, 0, 1'b0);
    while (exp_dec.size() > 0) begin
      e = exp_dec.pop_front(); chk_cnt++;
      if (obs_dec.size() == 0) $display("FAIL line_dec: no decode seen, want %h at cycle %0d", e.instr, e.cyc);
      else begin
        o = obs_dec.pop_front();
        if (o.instr !== e.instr || o.cyc != e.cyc)
          $display("FAIL line_dec: got %h at cycle %0d, want %h at cycle %0d", o.instr, o.cyc, e.instr, e.cyc);
        else pass_cnt++;
      end
    end
    while (exp_fetch.size() > 0) begin
      logic [AW-1:0] ea, oa;
      ea = exp_fetch.pop_front(); chk_cnt++;
      oa = (obs_fetch.size() > 0) ? obs_fetch.pop_front() : 8'hxx;
      if (oa !== ea) $display("FAIL line_fetch: got %h, want %h", oa, ea);
      else pass_cnt++;
    end
    chk_cnt++;
    if (halt_cyc != 12) $display("FAIL line_halt_cycle: got %0d, want 12", halt_cyc);
    else pass_cnt++;
    chk_cnt++;
    if (retired !== 16'd2 || pc !== 8'h12)
      $display("FAIL line_final: retired=%0d pc=%h, want retired=2 pc=12", retired, pc);
    else pass_cnt++;
  endtask

  task automatic test_ack_wait();
    mem[8'h20] = 16'h5555; mem[8'h21] = 16'hF000;
    run_prog(8'h20, 5, 1'b0);
    chk_cnt++;
    if (req_cycles != 6) $display("FAIL ackwait_req_len: got %0d cycles, want 6", req_cycles);
    else pass_cnt++;
    chk_cnt++;
    if (pc_drift != 0) $display("FAIL ackwait_pc_hold: pc moved %0d times before ack, want 0", pc_drift);
    else pass_cnt++;
    chk_cnt++;
    if (retired !== 16'd1 || pc !== 8'h21 || halt_cyc != 13)
      $display("FAIL ackwait_final: retired=%0d pc=%h halt_cyc=%0d, want 1 21 13", retired, pc, halt_cyc);
    else pass_cnt++;
  endtask

  task automatic test_jump_wrap();
    dec_t e, o;
    mem[8'hFF] = 16'h3000; mem[8'h00] = 16'hE0AB; mem[8'hAB] = 16'hF000;
    e.instr = 16'h3000; e.cyc = 3;  exp_dec.push_back(e);
    e.instr = 16'hE0AB; e.cyc = 7;  exp_dec.push_back(e);
    e.instr = 16'hF000; e.cyc = 10; exp_dec.push_back(e);
    exp_fetch.push_back(8'hFF); exp_fetch.push_back(8'h00); exp_fetch.push_back(8'hAB);
    run_prog(8'hFF, 0, 1'b0);
    while (exp_dec.size() > 0) begin
      e = exp_dec.pop_front(); chk_cnt++;
      if (obs_dec.size() == 0) $display("FAIL jump_dec: no decode seen, want %h at cycle %0d", e.instr, e.cyc);
      else begin
        o = obs_dec.pop_front();
        if (o.instr !== e.instr || o.cyc != e.cyc)
          $display("FAIL jump_dec: got %h at cycle %0d, want %h at cycle %0d", o.instr, o.cyc, e.instr, e.cyc);
        else pass_cnt++;
      end
    end
    while (exp_fetch.size() > 0) begin
      logic [AW-1:0] ea, oa;
      ea = exp_fetch.pop_front(); chk_cnt++;
      oa = (obs_fetch.size() > 0) ? obs_fetch.pop_front() : 8'hxx;
      if (oa !== ea) $display("FAIL jump_fetch: got %h, want %h", oa, ea);
      else pass_cnt++;
    end
    chk_cnt++;
    if (req_cycles != 1) $display("FAIL jump_no_exec: exec_req cycles=%0d, want 1", req_cycles);
    else pass_cnt++;
    chk_cnt++;
    if (retired !== 16'd1 || pc !== 8'hAB || halt_cyc != 11)
      $display("FAIL jump_final: retired=%0d pc=%h halt_cyc=%0d, want 1 ab 11", retired, pc, halt_cyc);
    else pass_cnt++;
  endtask

  task automatic test_spurious();
    dec_t e, o;
    mem[8'h30] = 16'h1111; mem[8'h31] = 16'hF000; mem[8'h77] = 16'h9999;
    e.instr = 16'h1111; e.cyc = 3; exp_dec.push_back(e);
    e.instr = 16'hF000; e.cyc = 7; exp_dec.push_back(e);
    exp_fetch.push_back(8'h30); exp_fetch.push_back(8'h31);
    run_prog(8'h30, 0, 1'b1);
    while (exp_dec.size() > 0) begin
      e = exp_dec.pop_front(); chk_cnt++;
      if (obs_dec.size() == 0) $display("FAIL spur_dec: no decode seen, want %h at cycle %0d", e.instr, e.cyc);
      else begin
        o = obs_dec.pop_front();
        if (o.instr !== e.instr || o.cyc != e.cyc)
          $display("FAIL spur_dec: got %h at cycle %0d, want %h at cycle %0d", o.instr, o.cyc, e.instr, e.cyc);
        else pass_cnt++;
      end
    end
    while (exp_fetch.size() > 0) begin
      logic [AW-1:0] ea, oa;
      ea = exp_fetch.pop_front(); chk_cnt++;
      oa = (obs_fetch.size() > 0) ? obs_fetch.pop_front() : 8'hxx;
      if (oa !== ea) $display("FAIL spur_fetch: got %h, want %h", oa, ea);
      else pass_cnt++;
    end
    chk_cnt++;
    if (retired !== 16'd1 || pc !== 8'h31 || halt_cyc != 8 || req_cycles != 1)
      $display("FAIL spur_final: retired=%0d pc=%h halt_cyc=%0d req=%0d, want 1 31 8 1",
               retired, pc, halt_cyc, req_cycles);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    bit done;
    mem[8'h40] = 16'h7000; mem[8'h41] = 16'hF000;
    start = 1'b1; start_addr = 8'h40;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (imem_rd !== 1'b1 || imem_addr !== 8'h40 || retired !== 16'd0)
      $display("FAIL restart_fetch: rd=%b addr=%h retired=%0d, want 1 40 0", imem_rd, imem_addr, retired);
    else pass_cnt++;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge clk); #1 exec_ack = exec_req;
      @(negedge clk);
      if (halted) done = 1'b1;
    end
    exec_ack = 1'b0;
    chk_cnt++;
    if (!done || retired !== 16'd1 || pc !== 8'h41)
      $display("FAIL restart_final: halted=%b retired=%0d pc=%h, want 1 1 41", done, retired, pc);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_exec();
    bit found;
    mem[8'h50] = 16'h1234; mem[8'h51] = 16'h4321;
    start = 1'b1; start_addr = 8'h50;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (c > 0) start = 1'b0;
      exec_ack = exec_req && (retired == 16'd0);
      @(negedge clk);
      if (exec_req && retired == 16'd1) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    exec_ack = 1'b0; start = 1'b0;
    chk_cnt++;
    if (!found || pc !== 8'h51) $display("FAIL midexec_setup: in_exec=%b pc=%h, want 1 51", found, pc);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if (exec_req !== 1'b0 || busy !== 1'b0 || pc !== '0 || retired !== '0 || id_instr !== '0)
      $display("FAIL midexec_async: req=%b busy=%b pc=%h retired=%0d, want all 0", exec_req, busy, pc, retired);
    else pass_cnt++;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || halted !== 1'b0 || imem_rd !== 1'b0 || exec_req !== 1'b0)
      $display("FAIL midexec_idle: busy=%b halted=%b rd=%b, want idle", busy, halted, imem_rd);
    else pass_cnt++;
    // start and reset together: reset wins
    @(posedge clk); #1 reset = 1'b1; start = 1'b1; start_addr = 8'h60;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || imem_rd !== 1'b0 || pc !== '0)
      $display("FAIL start_vs_reset: busy=%b rd=%b pc=%h, want 0 0 00", busy, imem_rd, pc);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    test_reset();
    test_straight_line();
    test_ack_wait();
    test_jump_wrap();
    test_spurious();
    test_restart();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
